// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: queues ALU commands in a small FIFO, issues them one at a
// time to an external combinational ALU and holds each captured result until
// the consumer takes it.
//
// Handshake rule for both the cmd_* and rsp_* interfaces: a transfer happens
// on a rising clk edge where valid and ready are both high; valid never
// depends on ready, and the payload is held stable while valid is high and
// ready is low.
module alu_cmd_driver #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_sel,
    input  logic [W-1:0]               cmd_a,
    input  logic [W-1:0]               cmd_b,
    output logic [W-1:0]               alu_a,
    output logic [W-1:0]               alu_b,
    output logic [2:0]                 alu_sel,
    input  logic [W-1:0]               alu_result,
    input  logic                       alu_zero,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [W-1:0]               rsp_result,
    output logic                       rsp_zero,
    output logic [2:0]                 rsp_sel,
    output logic [$clog2(DEPTH):0]     cmd_count,
    output logic                       busy,
    output logic                       zero_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = 3 + 2 * W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [W-1:0]      alu_a_q, alu_a_d;
    logic [W-1:0]      alu_b_q, alu_b_d;
    logic [2:0]        alu_sel_q, alu_sel_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [W-1:0]      rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic [2:0]        rsp_sel_q, rsp_sel_d;
    logic              zero_err_q, zero_err_d;

    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [FW-1:0]     head;

    // Full blocks pushes even when a pop happens in the same cycle.
    assign cmd_ready  = (count_q != CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = cmd_valid & cmd_ready;
    assign head       = mem_q[rd_ptr_q];

    // Command storage; entries are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_sel, cmd_a, cmd_b};
        end
    end

    // FSM next state, FIFO pop decision, ALU drive and response capture.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_sel_d    = rsp_sel_q;
        zero_err_d   = zero_err_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    alu_sel_d = head[FW-1 -: 3];
                    alu_a_d   = head[2*W-1 -: W];
                    alu_b_d   = head[W-1:0];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_sel_d    = alu_sel_q;
                rsp_valid_d  = 1'b1;
                if (alu_zero != (alu_result == '0)) begin
                    zero_err_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        alu_sel_d = head[FW-1 -: 3];
                        alu_a_d   = head[2*W-1 -: W];
                        alu_b_d   = head[W-1:0];
                        state_d   = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= 3'b111;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_sel_q    <= 3'b111;
            zero_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_sel_q    <= rsp_sel_d;
            zero_err_q   <= zero_err_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_sel    = rsp_sel_q;
    assign cmd_count  = count_q;
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign zero_err   = zero_err_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: a small ALU stub closes the datapath loop, the
// driver pushes hand-computed expected responses as commands are accepted,
// and a monitor pops and compares on every response handshake.
module tb_alu_cmd_driver;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int EW    = W + 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_sel;
    logic [W-1:0]  cmd_a;
    logic [W-1:0]  cmd_b;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [2:0]    alu_sel;
    logic [W-1:0]  alu_result;
    logic          alu_zero;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_result;
    logic          rsp_zero;
    logic [2:0]    rsp_sel;
    logic [CW-1:0] cmd_count;
    logic          busy;
    logic          zero_err;

    logic          force_zero;
    logic [W-1:0]  alu_res_raw;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;
    int            n_cmp;
    int            n_err;

    alu_cmd_driver #(.DEPTH(DEPTH), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_sel    (cmd_sel),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_sel    (rsp_sel),
        .cmd_count  (cmd_count),
        .busy       (busy),
        .zero_err   (zero_err)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    // ALU datapath stub; force_zero lets a test corrupt the zero flag.
    always_comb begin
        case (alu_sel)
            3'b000:  alu_res_raw = alu_a + alu_b;
            3'b001:  alu_res_raw = alu_a - alu_b;
            3'b010:  alu_res_raw = alu_a & alu_b;
            3'b011:  alu_res_raw = alu_a | alu_b;
            3'b100:  alu_res_raw = alu_a ^ alu_b;
            3'b101:  alu_res_raw = (alu_a < alu_b) ? 8'h01 : 8'h00;
            3'b110:  alu_res_raw = alu_a * alu_b;
            default: alu_res_raw = '0;
        endcase
    end
    assign alu_result = alu_res_raw;
    assign alu_zero   = force_zero | (alu_res_raw == '0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every response handshake must match the queue head.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp_unexpected: got %0h expected no response", {rsp_sel, rsp_result, rsp_zero});
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp_payload", 32'({rsp_sel, rsp_result, rsp_zero}), 32'(mon_exp));
            end
        end
    end

    // Offer one command for one cycle; record the expectation only if accepted.
    task automatic drive_cmd(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] er, input logic ez, output logic acc);
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        cmd_a     = a;
        cmd_b     = b;
        @(negedge clk);
        acc = cmd_ready;
        if (acc) exp_q.push_back({sel, er, ez});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || rsp_valid) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, 32'(exp_q.size() == 0 && !rsp_valid), 32'(1));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        exp_q.delete();
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Vector table for the backpressure test: sel, a, b, expected result, zero.
    logic [2:0]   bp_sel [6];
    logic [W-1:0] bp_a   [6];
    logic [W-1:0] bp_b   [6];
    logic [W-1:0] bp_r   [6];
    logic         bp_z   [6];

    initial begin
        logic       acc;
        logic [5:0] acc_bits;
        logic [9:0] hs_bits;

        bp_sel = '{OP_AND, OP_OR,  OP_XOR, OP_ADD, OP_SUB, OP_NOP};
        bp_a   = '{8'hF0,  8'hF0,  8'hAA,  8'hFF,  8'h03,  8'h12};
        bp_b   = '{8'h3C,  8'h0F,  8'hAA,  8'h01,  8'h05,  8'h34};
        bp_r   = '{8'h30,  8'hFF,  8'h00,  8'h00,  8'hFE,  8'h00};
        bp_z   = '{1'b0,   1'b0,   1'b1,   1'b1,   1'b0,   1'b1};

        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_sel    = 3'b000;
        cmd_a      = '0;
        cmd_b      = '0;
        rsp_ready  = 1'b0;
        force_zero = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_count",  32'(cmd_count),  32'(0));
        check("rst_cmd_ready",  32'(cmd_ready),  32'(1));
        check("rst_rsp_valid",  32'(rsp_valid),  32'(0));
        check("rst_rsp_result", 32'(rsp_result), 32'(0));
        check("rst_rsp_zero",   32'(rsp_zero),   32'(0));
        check("rst_rsp_sel",    32'(rsp_sel),    32'(3'b111));
        check("rst_alu_a",      32'(alu_a),      32'(0));
        check("rst_alu_b",      32'(alu_b),      32'(0));
        check("rst_alu_sel",    32'(alu_sel),    32'(3'b111));
        check("rst_busy",       32'(busy),       32'(0));
        check("rst_zero_err",   32'(zero_err),   32'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'(1));

        // Single ADD: response appears two edges after the push edge.
        rsp_ready = 1'b1;
        drive_cmd(OP_ADD, 8'h0F, 8'h01, 8'h10, 1'b0, acc);
        check("add_accepted", 32'(acc), 32'(1));
        check("add_lat_n0", 32'(rsp_valid), 32'(0));
        @(posedge clk);
        #1;
        check("add_lat_n1", 32'(rsp_valid), 32'(0));
        check("add_alu_drive", 32'({alu_sel, alu_a, alu_b}), 32'({OP_ADD, 8'h0F, 8'h01}));
        @(posedge clk);
        #1;
        check("add_lat_n2", 32'(rsp_valid), 32'(1));
        check("add_result", 32'({rsp_sel, rsp_result, rsp_zero}), 32'({OP_ADD, 8'h10, 1'b0}));
        wait_drain("add_drain", 20);
        check("add_zero_err", 32'(zero_err), 32'(0));

        // SUB then MUL back-to-back, both zero results.
        drive_cmd(OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, acc);
        drive_cmd(OP_MUL, 8'h10, 8'h10, 8'h00, 1'b1, acc);
        wait_drain("submul_drain", 20);
        check("submul_busy", 32'(busy), 32'(0));
        check("alu_hold_idle", 32'({alu_sel, alu_a, alu_b}), 32'({OP_MUL, 8'h10, 8'h10}));

        // Backpressure: six offers, five accepted, FIFO full.
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_cmd(bp_sel[i], bp_a[i], bp_b[i], bp_r[i], bp_z[i], acc);
            acc_bits[i] = acc;
        end
        check("bp_accept_pattern", 32'(acc_bits), 32'(6'b011111));
        check("bp_cmd_ready", 32'(cmd_ready), 32'(0));
        check("bp_cmd_count", 32'(cmd_count), 32'(4));
        check("bp_busy", 32'(busy), 32'(1));

        // Held response stays stable for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_rsp", 32'({rsp_valid, rsp_sel, rsp_result, rsp_zero}),
                  32'({1'b1, OP_AND, 8'h30, 1'b0}));
        end
        check("hold_alu", 32'({alu_sel, alu_a, alu_b}), 32'({OP_AND, 8'hF0, 8'h3C}));

        // Drain: one handshake every second cycle.
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            hs_bits[i] = rsp_valid & rsp_ready;
        end
        check("drain_rate", 32'(hs_bits), 32'(10'b0101010101));
        @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'(0));
        wait_drain("bp_drain", 20);

        // Reset while in ISSUE with three commands queued.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_cmd(OP_ADD, 8'(i + 1), 8'h02, 8'(i + 3), 1'b0, acc);
        end
        check("mid_cmd_count_full", 32'(cmd_count), 32'(4));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("mid_cmd_count_issue", 32'(cmd_count), 32'(3));
        check("mid_rsp_valid_issue", 32'(rsp_valid), 32'(0));
        rsp_ready = 1'b0;
        do_reset(1);
        check("mid_rst_cmd_count", 32'(cmd_count), 32'(0));
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("mid_rst_alu_sel", 32'(alu_sel), 32'(3'b111));
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'(1));
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("mid_no_rsp", 32'(rsp_valid), 32'(0));
        end
        check("mid_busy", 32'(busy), 32'(0));

        // Inconsistent zero flag sets the sticky error.
        force_zero = 1'b1;
        drive_cmd(OP_ADD, 8'h00, 8'h01, 8'h01, 1'b1, acc);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        force_zero = 1'b0;
        wait_drain("zerr_drain", 20);
        check("zerr_set", 32'(zero_err), 32'(1));
        drive_cmd(OP_ADD, 8'h02, 8'h03, 8'h05, 1'b0, acc);
        wait_drain("zerr_drain2", 20);
        check("zerr_sticky", 32'(zero_err), 32'(1));
        do_reset(1);
        check("zerr_cleared", 32'(zero_err), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
